data_sram_resp: RTL and testbench
=================================

// Module: data_sram_resp
// PURPOSE
//   Responder end of the CPU data SRAM port (we/addr/wdata/rdata). Serves the core's
//   loads/stores from a word RAM plus a small MMIO register window: LEDs, switches,
//   a free-running timer and a store counter. Sits beside the core in the SoC top.
//   Read data is combinational in the same cycle, so single-cycle ld.w writes back.
// PARAMETERS
//   ADDR_W     10        word-index bits of RAM (2**ADDR_W words of 32 bits)
//   MMIO_BASE  16'hBFAF  addr[31:16] value that selects the MMIO window
// PORTS
//   clk         in   1   single clock, all state updates on posedge
//   reset       in   1   synchronous, active-high reset
//   sram_we     in   1   write enable; write commits at the next posedge
//   sram_addr   in   32  byte address; bits [1:0] ignored
//   sram_wdata  in   32  write data
//   sram_rdata  out  32  read data, combinational from sram_addr
//   switch_in   in   16  board switches, sampled through 2-flop synchroniser
//   led_out     out  16  LED register value
// BEHAVIOUR
//   Decode: mmio_sel = (addr[31:16] == MMIO_BASE). Otherwise RAM, index = addr[ADDR_W+1:2];
//     upper address bits are not checked (RAM aliases across the space).
//   RAM: asynchronous read, synchronous write when sram_we & !mmio_sel.
//     RAM contents are not cleared by reset.
//   MMIO map (offset = addr[15:0]):
//     F000 LED    RW  bits[15:0]; reset 0; upper read bits 0
//     F004 TIMER  RW  +1 every cycle, wraps FFFF_FFFF->0; reset 0; write loads wdata
//     F008 SWITCH RO  {16'b0, switch_sync}; writes ignored
//     F00C STCNT  RO  +1 per committed RAM write, wraps; reset 0; writes ignored
//     any other offset in window: reads 0, writes ignored
//   Same cycle read+write, same address: rdata shows OLD value; new value is
//     visible from the next cycle.
//   TIMER write and increment in same cycle: the written value wins. The next
//     cycle shows wdata+1.
//   STCNT counts RAM writes only. MMIO writes do not increment it.
//   switch_sync: two flops, reset 0. switch_in is seen in rdata 2 cycles after it changes.
//   Reset values: led_out=0, timer=0, stcnt=0, switch_sync=0.
//     sram_rdata is combinational and has no reset value of its own; after reset,
//     MMIO reads return the reset register values.
//   Reset asserted mid-operation: a write presented in a cycle with reset=1 is dropped.
//     This applies to both RAM and MMIO. All registers take their reset values.
//   Latency: read 0 cycles (combinational); write 1 cycle (visible after posedge).
// CONFIGURATION
//   DSRAM_TIMER_EN defined: TIMER register implemented as described.
//   DSRAM_TIMER_EN undefined: no timer flops; F004 reads 0 and ignores writes.
//     All other behaviour is identical.
// TESTING
//   1. reset 2 cycles; read F000/F004/F00C -> 0; led_out=0.
//   2. we=1 addr=0x0000_0010 wdata=0xDEADBEEF. Same cycle, read of 0x10 returns the
//      old value. Next cycle it returns 0xDEADBEEF; STCNT=1.
//   3. Aliasing: write 0x1234 to 0x0000_0010. Read 0x1000_0010 -> 0x1234
//      (ADDR_W=10). Read 0x0000_0013 -> 0x1234.
//   4. we=1 addr=0xBFAF_F000 wdata=0xFFFF_A5A5. Next cycle led_out=0xA5A5 and
//      the LED read = 0x0000_A5A5. STCNT is unchanged.
//   5. TIMER: write 0xFFFF_FFFE, then read on the following cycles -> 0xFFFF_FFFF, 0, 1.
//      Without DSRAM_TIMER_EN, reads stay 0.
//   6. switch_in=0x00F0. SWITCH read is 0 for 2 cycles, then 0x0000_00F0.
//      Assert reset together with a we to RAM -> RAM word unchanged, STCNT=0.

Source files
------------

// File: rtl/data_sram_resp.sv
// Responder for the core's data SRAM port: word RAM plus an MMIO window (LED, TIMER, SWITCH, STCNT).
// Define DSRAM_TIMER_EN to build the free-running TIMER at offset F004; otherwise it reads 0.
module data_sram_resp #(
   parameter int          ADDR_W    = 10,
   parameter logic [15:0] MMIO_BASE = 16'hBFAF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sram_we,
   input  logic [31:0] sram_addr,
   input  logic [31:0] sram_wdata,
   output logic [31:0] sram_rdata,
   input  logic [15:0] switch_in,
   output logic [15:0] led_out
);

   localparam logic [15:0] OFF_LED    = 16'hF000;
   localparam logic [15:0] OFF_TIMER  = 16'hF004;
   localparam logic [15:0] OFF_SWITCH = 16'hF008;
   localparam logic [15:0] OFF_STCNT  = 16'hF00C;

   // Port contract: no handshake. Reads are combinational from sram_addr in the
   // same cycle; a write with sram_we=1 commits at the next posedge unless reset=1.
   logic              mmio_sel;
   logic [15:0]       mmio_off;
   logic [ADDR_W-1:0] ram_idx;
   logic              ram_we;
   logic              mmio_we;

   logic [31:0]       mem_q [0:(1<<ADDR_W)-1];
   logic [15:0]       led_q, led_d;
   logic [31:0]       stcnt_q, stcnt_d;
   logic [15:0]       sw_meta_q, sw_sync_q;
   logic [31:0]       timer_rd;
   logic              unused_bits;

   assign mmio_sel = (sram_addr[31:16] == MMIO_BASE);
   assign mmio_off = sram_addr[15:0];
   assign ram_idx  = sram_addr[ADDR_W+1:2];
   assign ram_we   = sram_we & ~mmio_sel & ~reset;
   assign mmio_we  = sram_we &  mmio_sel & ~reset;

   assign unused_bits = ^{sram_addr[1:0], sram_wdata[31:16]};

   // RAM has no reset: contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem_q[ram_idx] <= sram_wdata;
      end
   end

   always_comb begin
      led_d = led_q;
      if (mmio_we && mmio_off == OFF_LED) begin
         led_d = sram_wdata[15:0];
      end
   end

   always_comb begin
      stcnt_d = stcnt_q;
      if (ram_we) begin
         stcnt_d = stcnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         led_q     <= '0;
         stcnt_q   <= '0;
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         led_q     <= led_d;
         stcnt_q   <= stcnt_d;
         sw_meta_q <= switch_in;
         sw_sync_q <= sw_meta_q;
      end
   end

`ifdef DSRAM_TIMER_EN
   logic [31:0] timer_q, timer_d;

   // A write takes the written value and still counts this cycle, so the
   // register holds wdata+1 in the cycle after the write.
   always_comb begin
      timer_d = timer_q + 32'd1;
      if (mmio_we && mmio_off == OFF_TIMER) begin
         timer_d = sram_wdata + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   assign timer_rd = timer_q;
`else
   assign timer_rd = '0;
`endif

   always_comb begin
      sram_rdata = mem_q[ram_idx];
      if (mmio_sel) begin
         case (mmio_off)
            OFF_LED:    sram_rdata = {16'b0, led_q};
            OFF_TIMER:  sram_rdata = timer_rd;
            OFF_SWITCH: sram_rdata = {16'b0, sw_sync_q};
            OFF_STCNT:  sram_rdata = stcnt_q;
            default:    sram_rdata = '0;
         endcase
      end
   end

   assign led_out = led_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench for data_sram_resp: directed spec scenarios plus randomized traffic
// checked every cycle against a behavioural model (RAM array, register values, switch pipe).
module tb_data_sram_resp;

   localparam int ADDR_W = 10;

   logic        clk;
   logic        reset;
   logic        sram_we;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic [15:0] switch_in;
   logic [15:0] led_out;

   data_sram_resp #(.ADDR_W(ADDR_W), .MMIO_BASE(16'hBFAF)) dut (
      .clk        (clk),
      .reset      (reset),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .switch_in  (switch_in),
      .led_out    (led_out)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      reset = 1'b1; sram_we = 1'b0; sram_addr = '0; sram_wdata = '0; switch_in = '0;
   end

   // behavioural model state
   logic [31:0] m_mem   [0:(1<<ADDR_W)-1];
   bit          m_valid [0:(1<<ADDR_W)-1];
   logic [15:0] m_led;
   logic [31:0] m_timer;
   logic [31:0] m_stcnt;
   logic [15:0] m_sw_hist1, m_sw_hist2;
   bit          model_ok = 1'b0;

   logic [31:0] exp_q[$];
   logic [31:0] got_rdata;
   logic [15:0] got_led;
   logic [15:0] sw_drive = '0;
   int          tests  = 0;
   int          failed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
      int idx;
      known = 1'b1;
      if (a[31:16] == 16'hBFAF) begin
         case (a[15:0])
            16'hF000: return {16'h0, m_led};
            16'hF004: return m_timer;
            16'hF008: return {16'h0, m_sw_hist2};
            16'hF00C: return m_stcnt;
            default:  return 32'h0;
         endcase
      end
      idx = int'(a[ADDR_W+1:2]);
      known = m_valid[idx];
      return m_mem[idx];
   endfunction

   task automatic model_step(input logic rst, input logic we, input logic [31:0] a,
                             input logic [31:0] wd);
      int idx;
      if (rst) begin
         m_led = '0; m_timer = '0; m_stcnt = '0; m_sw_hist1 = '0; m_sw_hist2 = '0;
         model_ok = 1'b1;
         return;
      end
      m_sw_hist2 = m_sw_hist1;
      m_sw_hist1 = sw_drive;
`ifdef DSRAM_TIMER_EN
      if (we && a[31:16] == 16'hBFAF && a[15:0] == 16'hF004) m_timer = wd + 32'd1;
      else m_timer = m_timer + 32'd1;
`endif
      if (we && a[31:16] == 16'hBFAF) begin
         if (a[15:0] == 16'hF000) m_led = wd[15:0];
      end else if (we) begin
         idx = int'(a[ADDR_W+1:2]);
         m_mem[idx] = wd;
         m_valid[idx] = 1'b1;
         m_stcnt = m_stcnt + 32'd1;
      end
   endtask

   // driver + compare: one cycle, inputs applied after negedge, outputs sampled 1ns later
   task automatic cycle(input logic rst, input logic we, input logic [31:0] a,
                        input logic [31:0] wd);
      logic [31:0] e;
      bit known;
      @(negedge clk);
      reset = rst; sram_we = we; sram_addr = a; sram_wdata = wd; switch_in = sw_drive;
      #1;
      got_rdata = sram_rdata;
      got_led   = led_out;
      if (model_ok) begin
         check("led_out", {16'h0, got_led}, {16'h0, m_led});
         e = model_read(a, known);
         if (known) exp_q.push_back(e);
         if (known) begin
            e = exp_q.pop_front();
            check("rdata", got_rdata, e);
         end
      end
      model_step(rst, we, a, wd);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] wd;
      logic        we;
      logic        rst;
      for (int i = 0; i < (1 << ADDR_W); i++) m_valid[i] = 1'b0;

      cycle(1, 0, 32'h0, 32'h0);
      cycle(1, 0, 32'h0, 32'h0);
      cycle(0, 1, 32'h0000_0010, 32'h1111_1111);
      // reset 2 cycles; register reads return reset values
      cycle(1, 0, 32'h0, 32'h0);
      cycle(1, 0, 32'h0, 32'h0);
      cycle(0, 0, 32'hBFAF_F004, 32'h0); check("rst_timer", got_rdata, 32'h0);
      cycle(0, 0, 32'hBFAF_F000, 32'h0); check("rst_led_rd", got_rdata, 32'h0);
      check("rst_led_out", {16'h0, got_led}, 32'h0);
      cycle(0, 0, 32'hBFAF_F00C, 32'h0); check("rst_stcnt", got_rdata, 32'h0);

      // write then read: old value in the write cycle, new value after
      cycle(0, 1, 32'h0000_0010, 32'hDEAD_BEEF); check("wr_old", got_rdata, 32'h1111_1111);
      cycle(0, 0, 32'h0000_0010, 32'h0);         check("wr_new", got_rdata, 32'hDEAD_BEEF);
      cycle(0, 0, 32'hBFAF_F00C, 32'h0);         check("stcnt_1", got_rdata, 32'h1);

      // aliasing
      cycle(0, 1, 32'h0000_0010, 32'h0000_1234);
      cycle(0, 0, 32'h1000_0010, 32'h0); check("alias_hi", got_rdata, 32'h0000_1234);
      cycle(0, 0, 32'h0000_0013, 32'h0); check("alias_lo", got_rdata, 32'h0000_1234);

      // LED write
      cycle(0, 1, 32'hBFAF_F000, 32'hFFFF_A5A5);
      cycle(0, 0, 32'hBFAF_F000, 32'h0); check("led_rd", got_rdata, 32'h0000_A5A5);
      check("led_pin", {16'h0, got_led}, 32'h0000_A5A5);
      cycle(0, 0, 32'hBFAF_F00C, 32'h0); check("stcnt_2", got_rdata, 32'h2);
      cycle(0, 1, 32'hBFAF_F020, 32'h5555_5555); check("unmapped", got_rdata, 32'h0);

      // TIMER write and wrap
      cycle(0, 1, 32'hBFAF_F004, 32'hFFFF_FFFE);
`ifdef DSRAM_TIMER_EN
      cycle(0, 0, 32'hBFAF_F004, 32'h0); check("timer_0", got_rdata, 32'hFFFF_FFFF);
      cycle(0, 0, 32'hBFAF_F004, 32'h0); check("timer_1", got_rdata, 32'h0);
      cycle(0, 0, 32'hBFAF_F004, 32'h0); check("timer_2", got_rdata, 32'h1);
`else
      cycle(0, 0, 32'hBFAF_F004, 32'h0); check("timer_0", got_rdata, 32'h0);
      cycle(0, 0, 32'hBFAF_F004, 32'h0); check("timer_1", got_rdata, 32'h0);
      cycle(0, 0, 32'hBFAF_F004, 32'h0); check("timer_2", got_rdata, 32'h0);
`endif

      // switch synchroniser latency
      sw_drive = 16'h00F0;
      cycle(0, 1, 32'hBFAF_F008, 32'hFFFF_FFFF); check("sw_lat0", got_rdata, 32'h0);
      cycle(0, 0, 32'hBFAF_F008, 32'h0);         check("sw_lat1", got_rdata, 32'h0);
      cycle(0, 0, 32'hBFAF_F008, 32'h0);         check("sw_lat2", got_rdata, 32'h0000_00F0);

      // write during reset is dropped
      cycle(1, 1, 32'h0000_0010, 32'h0BAD_0BAD);
      cycle(0, 0, 32'h0000_0010, 32'h0); check("rst_drop_ram", got_rdata, 32'h0000_1234);
      cycle(0, 0, 32'hBFAF_F00C, 32'h0); check("rst_drop_stcnt", got_rdata, 32'h0);
      cycle(1, 1, 32'hBFAF_F000, 32'h0000_7777);
      cycle(0, 0, 32'hBFAF_F000, 32'h0); check("rst_drop_led", got_rdata, 32'h0);

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 99) == 0);
         we  = 1'($urandom_range(0, 1));
         wd  = $urandom();
         a   = $urandom();
         if ($urandom_range(0, 7) == 0) sw_drive = 16'($urandom());
         case ($urandom_range(0, 3))
            0, 1: begin
               a[ADDR_W+1:2] = ADDR_W'($urandom_range(0, 31));
               if (a[31:16] == 16'hBFAF) a[31:16] = 16'h0;
            end
            2: a = {16'hBFAF, 16'hF000 + 16'($urandom_range(0, 3) * 4)} | 32'($urandom_range(0, 3));
            default: a[31:16] = 16'hBFAF;
         endcase
         cycle(rst, we, a, wd);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
